// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
//   mem_size_e : load access size (byte, half, word, dword)
//   *_W        : bit widths of each load size
package wb_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DWORD_W = 64;

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load-data formatter.
// Shifts the raw aligned read word down to the addressed byte, keeps the
// access-size low bits and sign- or zero-extends them to DATA_W. Also flags
// misaligned accesses and dword loads on a 32-bit datapath.
//   rdata    in  DATA_W  raw aligned memory word
//   size     in  2       mem_size_e
//   zero_ext in  1       zero-extend instead of sign-extend
//   addr_lo  in  OFF_W   byte offset within the word
//   wdata    out DATA_W  formatted load result
//   misalign out 1       access is misaligned or illegal for DATA_W
module wb_load_fmt
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              zero_ext,
  input  logic [OFF_W-1:0]  addr_lo,
  output logic [DATA_W-1:0] wdata,
  output logic              misalign
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic              sign;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // A keep-mask avoids zero-width replications when the size equals DATA_W.
  always_comb begin
    keep_mask = '1;
    sign      = 1'b0;
    misalign  = 1'b0;
    unique case (size)
      MEM_B: begin
        keep_mask = DATA_W'({BYTE_W{1'b1}});
        sign      = shifted[BYTE_W-1];
      end
      MEM_H: begin
        keep_mask = DATA_W'({HALF_W{1'b1}});
        sign      = shifted[HALF_W-1];
        misalign  = addr_lo[0];
      end
      MEM_W: begin
        keep_mask = DATA_W'({WORD_W{1'b1}});
        sign      = shifted[WORD_W-1];
        misalign  = (addr_lo[1:0] != 2'b00);
      end
      MEM_D: begin
        keep_mask = '1;
        sign      = shifted[DATA_W-1];
        misalign  = (addr_lo != '0) || (DATA_W != DWORD_W);
      end
    endcase
  end

  assign wdata = (shifted & keep_mask) | (~keep_mask & {DATA_W{sign & ~zero_ext}});

endmodule

// File: rtl/writeback_unit.sv
// Registered writeback stage: ME/WB pipeline register, load formatting,
// x0 write suppression, misaligned-load detection and retired-instruction
// counter. Outputs are combinational from the WB register.
//   clk, rst                 clock, synchronous active-high reset
//   valid_i, stall_i, flush_i pipeline control from ME / hazard unit
//   rf_we_i, rf_waddr_i      destination write enable and register
//   mem2rf_i, mem_size_i, mem_unsigned_i, mem_addr_lo_i, mem_rdata_i  load info
//   alu_result_i             ALU result
//   rf_we_o/rf_waddr_o/rf_wdata_o  RF write port (DE)
//   rf_data_o                bypass data (EXE)
//   rf_dst_o/rf_we_hu_o      bypass destination / enable (HU)
//   misalign_o               WB entry is a misaligned or illegal load
//   instret_o                retired-instruction count
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 64,
  localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              rf_we_i,
  input  logic [ADDR_W-1:0] rf_waddr_i,
  input  logic              mem2rf_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [OFF_W-1:0]  mem_addr_lo_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic [ADDR_W-1:0] rf_dst_o,
  output logic              rf_we_hu_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  instret_o
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("writeback_unit: DATA_W must be 32 or 64");
  end

  logic              valid_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              mem2rf_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [OFF_W-1:0]  addr_lo_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] alu_q;
  logic [CNT_W-1:0]  instret_q;
  logic [CNT_W-1:0]  instret_d;

  logic [DATA_W-1:0] fmt_wdata;
  logic              fmt_misalign;
  logic              misalign;
  logic              retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      mem2rf_q   <= 1'b0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      addr_lo_q  <= '0;
      rdata_q    <= '0;
      alu_q      <= '0;
      instret_q  <= '0;
    end else begin
      // Payload is left untouched on flush; only valid matters.
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (!stall_i) begin
        valid_q    <= valid_i;
        we_q       <= rf_we_i;
        waddr_q    <= rf_waddr_i;
        mem2rf_q   <= mem2rf_i;
        size_q     <= mem_size_i;
        unsigned_q <= mem_unsigned_i;
        addr_lo_q  <= mem_addr_lo_i;
        rdata_q    <= mem_rdata_i;
        alu_q      <= alu_result_i;
      end
      instret_q <= instret_d;
    end
  end

  wb_load_fmt #(
    .DATA_W (DATA_W)
  ) u_load_fmt (
    .rdata    (rdata_q),
    .size     (size_q),
    .zero_ext (unsigned_q),
    .addr_lo  (addr_lo_q),
    .wdata    (fmt_wdata),
    .misalign (fmt_misalign)
  );

  assign misalign = valid_q & mem2rf_q & fmt_misalign;

  // The entry leaves WB when it is not stalled or is being flushed out.
  assign retire = valid_q & (~stall_i | flush_i) & ~misalign;

  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  assign rf_we_o    = valid_q & we_q & (waddr_q != '0) & ~misalign;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = mem2rf_q ? fmt_wdata : alu_q;
  assign rf_data_o  = rf_wdata_o;
  assign rf_dst_o   = rf_waddr_o;
  assign rf_we_hu_o = rf_we_o;
  assign misalign_o = misalign;
  assign instret_o  = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench: dut_a is the 32-bit datapath with a 64-bit counter, dut_b
// the 64-bit datapath with a 4-bit counter for the wrap case.
module tb_writeback_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic valid_a = 1'b0;
  logic valid_b = 1'b0;
  logic we = 1'b0;
  logic [4:0] waddr = '0;
  logic m2r = 1'b0;
  logic [1:0] size = '0;
  logic uns = 1'b0;
  logic [1:0] off_a = '0;
  logic [2:0] off_b = '0;
  logic [31:0] rdata_a = '0;
  logic [31:0] alu_a = '0;
  logic [63:0] rdata_b = '0;
  logic [63:0] alu_b = '0;

  logic        we_a, we_hu_a, mis_a;
  logic [4:0]  waddr_oa, dst_a;
  logic [31:0] wdata_a, data_a;
  logic [63:0] instret_a;
  logic        we_b, we_hu_b, mis_b;
  logic [4:0]  waddr_ob, dst_b;
  logic [63:0] wdata_b, data_b;
  logic [3:0]  instret_b;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  writeback_unit #(.ADDR_W(5), .DATA_W(32), .CNT_W(64)) dut_a (
    .clk(clk), .rst(rst), .valid_i(valid_a), .stall_i(stall), .flush_i(flush),
    .rf_we_i(we), .rf_waddr_i(waddr), .mem2rf_i(m2r), .mem_size_i(size),
    .mem_unsigned_i(uns), .mem_addr_lo_i(off_a), .mem_rdata_i(rdata_a),
    .alu_result_i(alu_a), .rf_we_o(we_a), .rf_waddr_o(waddr_oa), .rf_wdata_o(wdata_a),
    .rf_data_o(data_a), .rf_dst_o(dst_a), .rf_we_hu_o(we_hu_a), .misalign_o(mis_a),
    .instret_o(instret_a)
  );

  writeback_unit #(.ADDR_W(5), .DATA_W(64), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .valid_i(valid_b), .stall_i(stall), .flush_i(flush),
    .rf_we_i(we), .rf_waddr_i(waddr), .mem2rf_i(m2r), .mem_size_i(size),
    .mem_unsigned_i(uns), .mem_addr_lo_i(off_b), .mem_rdata_i(rdata_b),
    .alu_result_i(alu_b), .rf_we_o(we_b), .rf_waddr_o(waddr_ob), .rf_wdata_o(wdata_b),
    .rf_data_o(data_b), .rf_dst_o(dst_b), .rf_we_hu_o(we_hu_b), .misalign_o(mis_b),
    .instret_o(instret_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic exp_we, input logic [4:0] exp_waddr,
                         input logic [31:0] exp_wdata, input logic exp_mis,
                         input logic [63:0] exp_cnt);
    check_eq({tag, ".we"}, 64'(we_a), 64'(exp_we));
    check_eq({tag, ".we_hu"}, 64'(we_hu_a), 64'(exp_we));
    check_eq({tag, ".waddr"}, 64'(waddr_oa), 64'(exp_waddr));
    check_eq({tag, ".dst"}, 64'(dst_a), 64'(exp_waddr));
    check_eq({tag, ".wdata"}, 64'(wdata_a), 64'(exp_wdata));
    check_eq({tag, ".data"}, 64'(data_a), 64'(exp_wdata));
    check_eq({tag, ".mis"}, 64'(mis_a), 64'(exp_mis));
    check_eq({tag, ".cnt"}, instret_a, exp_cnt);
  endtask

  task automatic check_b(input string tag, input logic exp_we, input logic [4:0] exp_waddr,
                         input logic [63:0] exp_wdata, input logic exp_mis,
                         input logic [3:0] exp_cnt);
    check_eq({tag, ".we"}, 64'(we_b), 64'(exp_we));
    check_eq({tag, ".waddr"}, 64'(waddr_ob), 64'(exp_waddr));
    check_eq({tag, ".wdata"}, wdata_b, exp_wdata);
    check_eq({tag, ".data"}, data_b, exp_wdata);
    check_eq({tag, ".mis"}, 64'(mis_b), 64'(exp_mis));
    check_eq({tag, ".cnt"}, 64'(instret_b), 64'(exp_cnt));
  endtask

  // Present one instruction at the next negedge; return 1 time unit after capture.
  task automatic step(input logic va, input logic vb, input logic w, input logic [4:0] rd,
                      input logic mr, input logic [1:0] sz, input logic u,
                      input logic [2:0] off, input logic [63:0] rdata,
                      input logic [63:0] alu);
    @(negedge clk);
    valid_a = va;
    valid_b = vb;
    we      = w;
    waddr   = rd;
    m2r     = mr;
    size    = sz;
    uns     = u;
    off_a   = off[1:0];
    off_b   = off;
    rdata_a = rdata[31:0];
    rdata_b = rdata;
    alu_a   = alu[31:0];
    alu_b   = alu;
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] RD32 = 64'h0000_0000_80F0_7F81;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_a("rst_a", 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
    check_b("rst_b", 1'b0, 5'd0, 64'h0, 1'b0, 4'd0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_a("idle", 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);

    // Loads on the 32-bit datapath
    step(1, 0, 1, 5, 1, 2'd0, 0, 3, RD32, 0);
    check_a("lb3", 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 64'd0);
    step(1, 0, 1, 5, 1, 2'd0, 1, 0, RD32, 0);
    check_a("lbu0", 1'b1, 5'd5, 32'h0000_0081, 1'b0, 64'd1);
    step(1, 0, 1, 5, 1, 2'd1, 0, 2, RD32, 0);
    check_a("lh2", 1'b1, 5'd5, 32'hFFFF_80F0, 1'b0, 64'd2);
    step(1, 0, 1, 5, 1, 2'd1, 1, 2, RD32, 0);
    check_a("lhu2", 1'b1, 5'd5, 32'h0000_80F0, 1'b0, 64'd3);
    step(1, 0, 1, 5, 1, 2'd2, 0, 0, RD32, 0);
    check_a("lw0", 1'b1, 5'd5, 32'h80F0_7F81, 1'b0, 64'd4);

    // Misaligned / illegal loads: no write, no retirement
    step(1, 0, 1, 5, 1, 2'd1, 0, 1, RD32, 0);
    check_a("lh1", 1'b0, 5'd5, 32'hFFFF_F07F, 1'b1, 64'd5);
    step(1, 0, 1, 5, 1, 2'd2, 0, 2, RD32, 0);
    check_a("lw2", 1'b0, 5'd5, 32'h0000_80F0, 1'b1, 64'd5);
    step(1, 0, 1, 5, 1, 2'd3, 0, 0, RD32, 0);
    check_a("ld32", 1'b0, 5'd5, 32'h80F0_7F81, 1'b1, 64'd5);

    // x0 write suppressed but retires
    step(1, 0, 1, 0, 0, 2'd0, 0, 0, 0, 64'h1234);
    check_a("x0", 1'b0, 5'd0, 32'h1234, 1'b0, 64'd5);
    step(1, 0, 1, 7, 0, 2'd0, 0, 0, 0, 64'hCAFE);
    check_a("alu7", 1'b1, 5'd7, 32'hCAFE, 1'b0, 64'd6);

    // Stall for 3 cycles: outputs held, no retirement
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 9, 0, 2'd0, 0, 0, 0, 64'hBEEF);
      check_a("stall", 1'b1, 5'd7, 32'hCAFE, 1'b0, 64'd6);
    end
    stall = 1'b0;
    step(1, 0, 1, 9, 0, 2'd0, 0, 0, 0, 64'hBEEF);
    check_a("unstall", 1'b1, 5'd9, 32'hBEEF, 1'b0, 64'd7);

    // Flush drops the incoming entry; the current one retires
    flush = 1'b1;
    step(1, 0, 1, 10, 0, 2'd0, 0, 0, 0, 64'h55);
    check_eq("flush.we", 64'(we_a), 64'd0);
    check_eq("flush.mis", 64'(mis_a), 64'd0);
    check_eq("flush.cnt", instret_a, 64'd8);
    flush = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("postflush.we", 64'(we_a), 64'd0);
    check_eq("postflush.cnt", instret_a, 64'd8);

    // Flush together with stall: flush wins
    step(1, 0, 1, 11, 0, 2'd0, 0, 0, 0, 64'h77);
    check_a("alu11", 1'b1, 5'd11, 32'h77, 1'b0, 64'd8);
    flush = 1'b1;
    stall = 1'b1;
    step(1, 0, 1, 12, 0, 2'd0, 0, 0, 0, 64'h88);
    check_eq("flst.we", 64'(we_a), 64'd0);
    check_eq("flst.cnt", instret_a, 64'd9);
    flush = 1'b0;
    stall = 1'b0;

    // 64-bit datapath, 4-bit counter wrap
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 1, 1, 0, 2'd0, 0, 0, 0, 64'(i));
    end
    check_b("pre15", 1'b1, 5'd1, 64'd14, 1'b0, 4'd14);
    step(0, 1, 1, 2, 1, 2'd2, 1, 4, 64'hFFFF_FFFF_0000_0000, 0);
    check_b("lwu4", 1'b1, 5'd2, 64'h0000_0000_FFFF_FFFF, 1'b0, 4'd15);
    step(0, 1, 1, 2, 1, 2'd3, 0, 0, 64'hFFFF_FFFF_0000_0000, 0);
    check_b("ld0_wrap", 1'b1, 5'd2, 64'hFFFF_FFFF_0000_0000, 1'b0, 4'd0);
    step(0, 1, 1, 2, 1, 2'd3, 0, 4, 64'hFFFF_FFFF_0000_0000, 0);
    check_b("ld4", 1'b0, 5'd2, 64'h0000_0000_FFFF_FFFF, 1'b1, 4'd1);
    step(0, 1, 1, 2, 1, 2'd2, 0, 4, 64'h8000_0000_0000_0000, 0);
    check_b("lw4", 1'b1, 5'd2, 64'hFFFF_FFFF_8000_0000, 1'b0, 4'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("b_idle.we", 64'(we_b), 64'd0);
    check_eq("b_idle.cnt", 64'(instret_b), 64'd2);
    check_eq("a_quiet.cnt", instret_a, 64'd9);

    // Reset wins over flush and stall
    step(1, 0, 1, 13, 0, 2'd0, 0, 0, 0, 64'h99);
    check_a("alu13", 1'b1, 5'd13, 32'h99, 1'b0, 64'd9);
    rst = 1'b1;
    flush = 1'b1;
    stall = 1'b1;
    step(1, 1, 1, 14, 0, 2'd0, 0, 0, 0, 64'hAA);
    check_a("rst_win_a", 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
    check_b("rst_win_b", 1'b0, 5'd0, 64'h0, 1'b0, 4'd0);
    rst = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("post_rst.cnt", instret_a, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
